// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package int_seq_pkg;

    localparam int PC_W           = 32;
    localparam int DATA_W         = 16;
    localparam int CCR_W          = 3;
    localparam int INT_PUSH_BEATS = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_HI  = 3'd2,
        PUSH_LO  = 3'd3,
        PUSH_CCR = 3'd4,
        VECTOR   = 3'd5
    } int_state_t;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector for the external interrupt plus a one-deep pending latch.
// The pending request is dropped when the sequencer commits to DRAIN.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic interrupt_i,
    input  logic set_clr_i,
    output logic edge_o,
    output logic pending_o
);

    logic int_q;
    logic pending_q;

    assign edge_o    = interrupt_i & ~int_q;
    assign pending_o = pending_q;

    // Track the previous interrupt level and collapse any edges into one request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            int_q <= interrupt_i;
            if (set_clr_i) begin
                pending_q <= 1'b0;
            end else if (edge_o) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: freeze fetch, drain the pipe, push PC hi/lo and CCR,
// then redirect fetch to the vector and mask until the decoder reports rti.
module int_sequencer #(
    parameter int          PC_W         = int_seq_pkg::PC_W,
    parameter int          DATA_W       = int_seq_pkg::DATA_W,
    parameter int          CCR_W        = int_seq_pkg::CCR_W,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [CCR_W-1:0]  ccr_in,
    input  logic              pipe_busy,
    input  logic              rti_done,
    output logic              freeze,
    output logic              flush,
    output logic              stack_wr,
    output logic [DATA_W-1:0] stack_data,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_addr,
    output logic              int_ack,
    output logic              masked
);

    import int_seq_pkg::*;

    localparam int             CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

    int_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [PC_W-1:0]     pc_save_q;
    logic [CCR_W-1:0]    ccr_save_q;
    logic                masked_q;
    logic                freeze_q, flush_q, stack_wr_q, pc_load_q, int_ack_q;
    logic [DATA_W-1:0]   stack_data_q;
    logic                int_edge, pending, enter_drain;

    int_edge_latch u_edge (
        .clk         (clk),
        .rst         (rst),
        .interrupt_i (interrupt),
        .set_clr_i   (enter_drain),
        .edge_o      (int_edge),
        .pending_o   (pending)
    );

    // Next-state selection; DRAIN may stretch while the pipe still has a multi-cycle op.
    always_comb begin
        state_d     = state_q;
        enter_drain = 1'b0;
        case (state_q)
            IDLE: begin
                if ((int_edge | pending) & ~masked_q) begin
                    state_d     = DRAIN;
                    enter_drain = 1'b1;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !pipe_busy) begin
                    state_d = PUSH_HI;
                end
            end
            PUSH_HI:  state_d = PUSH_LO;
            PUSH_LO:  state_d = PUSH_CCR;
            PUSH_CCR: state_d = VECTOR;
            VECTOR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, drain counter, save registers, mask and outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pc_save_q    <= '0;
            ccr_save_q   <= '0;
            masked_q     <= 1'b0;
            freeze_q     <= 1'b0;
            flush_q      <= 1'b0;
            stack_wr_q   <= 1'b0;
            pc_load_q    <= 1'b0;
            int_ack_q    <= 1'b0;
            stack_data_q <= '0;
        end else begin
            state_q <= state_d;

            if (enter_drain) begin
                pc_save_q  <= pc_in;
                ccr_save_q <= ccr_in;
                cnt_q      <= CNT_INIT;
            end else if ((state_q == DRAIN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (state_q == VECTOR) begin
                masked_q <= 1'b1;
            end else if (rti_done) begin
                masked_q <= 1'b0;
            end

            freeze_q   <= (state_d != IDLE);
            stack_wr_q <= (state_d == PUSH_HI) || (state_d == PUSH_LO) || (state_d == PUSH_CCR);
            flush_q    <= (state_d == VECTOR);
            pc_load_q  <= (state_d == VECTOR);
            int_ack_q  <= (state_d == VECTOR);

            case (state_d)
                PUSH_HI:  stack_data_q <= pc_save_q[2*DATA_W-1:DATA_W];
                PUSH_LO:  stack_data_q <= pc_save_q[DATA_W-1:0];
                PUSH_CCR: stack_data_q <= {{(DATA_W-CCR_W){1'b0}}, ccr_save_q};
                default:  stack_data_q <= '0;
            endcase
        end
    end

    assign freeze       = freeze_q;
    assign flush        = flush_q;
    assign stack_wr     = stack_wr_q;
    assign stack_data   = stack_data_q;
    assign pc_load      = pc_load_q;
    assign pc_load_addr = VECTOR_ADDR[PC_W-1:0];
    assign int_ack      = int_ack_q;
    assign masked       = masked_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with hand-computed push data and cycle timing.
module tb_int_sequencer;

    import int_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupt;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic        pipe_busy;
    logic        rti_done;
    logic        freeze, flush, stack_wr, pc_load, int_ack, masked;
    logic [15:0] stack_data;
    logic [31:0] pc_load_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .interrupt    (interrupt),
        .pc_in        (pc_in),
        .ccr_in       (ccr_in),
        .pipe_busy    (pipe_busy),
        .rti_done     (rti_done),
        .freeze       (freeze),
        .flush        (flush),
        .stack_wr     (stack_wr),
        .stack_data   (stack_data),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .int_ack      (int_ack),
        .masked       (masked)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic intr, input logic busy, input logic rti);
        interrupt = intr;
        pipe_busy = busy;
        rti_done  = rti;
    endtask

    // All sequencing outputs quiet, with the given mask level.
    task automatic checkQuiet(input string tag, input logic expMasked);
        checkOutput({tag, " freeze"},   32'(freeze),     32'd0);
        checkOutput({tag, " stack_wr"}, 32'(stack_wr),   32'd0);
        checkOutput({tag, " data"},     32'(stack_data), 32'd0);
        checkOutput({tag, " pc_load"},  32'(pc_load),    32'd0);
        checkOutput({tag, " int_ack"},  32'(int_ack),    32'd0);
        checkOutput({tag, " flush"},    32'(flush),      32'd0);
        checkOutput({tag, " masked"},   32'(masked),     32'(expMasked));
    endtask

    task automatic idleCycles(input string tag, input int n, input logic expMasked);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput($sformatf("%s i%0d freeze", tag, i), 32'(freeze), 32'd0);
            checkOutput($sformatf("%s i%0d masked", tag, i), 32'(masked), 32'(expMasked));
        end
    endtask

    // Called at cycle 0 (just after the edge that entered DRAIN); ends in the first IDLE cycle.
    task automatic runService(input string tag, input logic [31:0] pc, input logic [2:0] ccr,
                              input int extra, input int pulseAt);
        int wrBeats;
        wrBeats = 0;
        for (int k = 0; k <= 7 + extra; k++) begin
            logic [31:0] expFrz, expWr, expVec, expData, expMask;
            expFrz  = 32'(k <= 6 + extra);
            expWr   = 32'((k >= 3 + extra) && (k <= 5 + extra));
            expVec  = 32'(k == 6 + extra);
            expMask = 32'(k == 7 + extra);
            if (k == 3 + extra)      expData = {16'h0, pc[31:16]};
            else if (k == 4 + extra) expData = {16'h0, pc[15:0]};
            else if (k == 5 + extra) expData = {29'h0, ccr};
            else                     expData = 32'h0;
            checkOutput($sformatf("%s k%0d freeze", tag, k),   32'(freeze),     expFrz);
            checkOutput($sformatf("%s k%0d stack_wr", tag, k), 32'(stack_wr),   expWr);
            checkOutput($sformatf("%s k%0d data", tag, k),     32'(stack_data), expData);
            checkOutput($sformatf("%s k%0d pc_load", tag, k),  32'(pc_load),    expVec);
            checkOutput($sformatf("%s k%0d int_ack", tag, k),  32'(int_ack),    expVec);
            checkOutput($sformatf("%s k%0d flush", tag, k),    32'(flush),      expVec);
            checkOutput($sformatf("%s k%0d masked", tag, k),   32'(masked),     expMask);
            if (stack_wr) wrBeats++;
            pipe_busy = (extra != 0) && (k < 2 + extra);
            if (k == pulseAt) interrupt = 1'b1;
            else if (pulseAt >= 0 && k == pulseAt + 1) interrupt = 1'b0;
            if (k < 7 + extra) tick();
        end
        checkOutput({tag, " beats"}, 32'(wrBeats), 32'(INT_PUSH_BEATS));
    endtask

    initial begin
        rst    = 1'b1;
        pc_in  = 32'h0;
        ccr_in = 3'b000;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        tick();
        tick();
        checkQuiet("reset", 1'b0);
        checkOutput("reset vec_addr", pc_load_addr, 32'h0000_0000);
        rst = 1'b0;
        tick();
        checkQuiet("post reset", 1'b0);

        // First service, with a second edge arriving during PUSH_LO.
        pc_in  = 32'h0001_2345;
        ccr_in = 3'b101;
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        runService("s1", 32'h0001_2345, 3'b101, 0, 4);
        idleCycles("s1 masked", 10, 1'b1);

        // rti releases the mask; the pending edge starts a new sequence one clock later.
        pc_in  = 32'hABCD_1234;
        ccr_in = 3'b010;
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        checkQuiet("s2 unmask", 1'b0);
        tick();
        runService("s2", 32'hABCD_1234, 3'b010, 0, -1);
        idleCycles("s2 after", 5, 1'b1);

        // Three edges while masked collapse into one service, stretched by pipe_busy.
        for (int p = 0; p < 3; p++) begin
            interrupt = 1'b1;
            tick();
            interrupt = 1'b0;
            tick();
            checkOutput($sformatf("mask edge%0d freeze", p), 32'(freeze), 32'd0);
        end
        pc_in  = 32'h00FF_FF00;
        ccr_in = 3'b111;
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        tick();
        runService("s3", 32'h00FF_FF00, 3'b111, 4, -1);
        idleCycles("s3 after", 6, 1'b1);

        // rti and a new edge in the same cycle.
        pc_in  = 32'h1357_2468;
        ccr_in = 3'b011;
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        rti_done = 1'b0;
        checkQuiet("same unmask", 1'b0);
        tick();
        runService("s4", 32'h1357_2468, 3'b011, 0, -1);

        // Unmask, then reset in the middle of PUSH_HI.
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        interrupt = 1'b0;
        idleCycles("pre rst", 2, 1'b0);
        pc_in  = 32'hCAFE_0042;
        ccr_in = 3'b001;
        interrupt = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkOutput("rst pushhi wr", 32'(stack_wr), 32'd1);
        checkOutput("rst pushhi data", 32'(stack_data), 32'h0000_CAFE);
        #2;
        rst = 1'b1;
        #1;
        checkQuiet("async rst", 1'b0);
        @(posedge clk);
        #1;
        checkQuiet("held rst", 1'b0);
        pc_in  = 32'h8000_7FFF;
        ccr_in = 3'b110;
        rst = 1'b0;
        tick();
        runService("s5", 32'h8000_7FFF, 3'b110, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt entry sequencer for the 5-stage RISC pipeline. Detects a rising edge on `interrupt`, freezes fetch, waits for the pipeline to drain, then pushes the 32-bit resume PC (two 16-bit beats) and the CCR onto the data-memory stack and redirects fetch to the interrupt vector. It sits beside the ID stage. It drives the fetch PC enable/select path and the memory-stage stack-write port, and masks further interrupts until the decoder reports an `rti`.

## Interface
Parameters:
- `PC_W`, 32, PC width
- `DATA_W`, 16, memory/stack word width
- `CCR_W`, 3, condition-code width
- `DRAIN_CYCLES`, 3, minimum freeze cycles before the first push (ID/EX/MEM empty)
- `VECTOR_ADDR`, 32'h0000_0000, PC loaded on interrupt entry

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `interrupt` in 1: external request, rising-edge sensitive
- `pc_in` in PC_W: address of the next instruction to execute (resume PC)
- `ccr_in` in CCR_W: current flags
- `pipe_busy` in 1: a multi-cycle op (call/ret/rti/stack pop) is in flight; drain must not end while high
- `rti_done` in 1: one-cycle pulse from the decoder when `rti` completes
- `freeze` out 1: forces fetch PC enable low and inserts bubbles in ID
- `flush` out 1: clears IF/ID
- `stack_wr` out 1: push request to the memory stage (SP decrement by the stack logic)
- `stack_data` out DATA_W: word to push
- `pc_load` out 1: select `pc_load_addr` as next PC
- `pc_load_addr` out PC_W: vector address
- `int_ack` out 1: one-cycle acknowledge
- `masked` out 1: interrupt service in progress

## Operation
- Edge detect: `edge = interrupt & ~int_q`. `int_q` resets to 0, so a high level at reset release counts as an edge.
- `pending` sets on `edge` and clears when DRAIN is entered. It is one deep: multiple edges collapse into one.
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_CCR, VECTOR. Outputs are Moore, decoded from the state.
- IDLE → DRAIN when `(edge | pending) & ~masked`.
  - On entry, capture `pc_in` into `pc_save`, capture `ccr_in` into `ccr_save`, and load `cnt = DRAIN_CYCLES-1`.
- DRAIN: `freeze=1`; `cnt` decrements to 0 and holds there. Exit to PUSH_HI when `cnt==0 & ~pipe_busy`.
- PUSH_HI: `freeze=1`, `stack_wr=1`, `stack_data=pc_save[31:16]`.
- PUSH_LO: `freeze=1`, `stack_wr=1`, `stack_data=pc_save[15:0]`.
- PUSH_CCR: `freeze=1`, `stack_wr=1`, `stack_data={13'b0, ccr_save}`.
- VECTOR: `freeze=1`, `flush=1`, `pc_load=1`, `int_ack=1`. The `masked` register sets on leaving VECTOR, and the state returns to IDLE.
- The push order is high, low, CCR, so `rti` pops CCR, low, then high.
- `masked` clears on `rti_done`.
  - If `rti_done` and `edge` occur in the same cycle, `masked` clears and `pending` sets; DRAIN is entered on the next edge of `clk`.
- Edges while `masked` or mid-sequence set `pending` and are serviced after `rti_done`.
- `rti_done` while not masked: ignored.
- `pc_load_addr` is constant `VECTOR_ADDR`. `stack_data=0` outside the push states.

## Timing
- Reset (async): state=IDLE, `int_q`=`pending`=`masked`=0, `cnt`=0, `pc_save`=`ccr_save`=0. All outputs are 0 (`pc_load_addr` stays `VECTOR_ADDR`).
- Reset mid-sequence aborts immediately. No further `stack_wr`; partial pushes are not undone.
- Edge seen at rising edge n of `clk`, with `pipe_busy=0` and DRAIN_CYCLES=3:
  - DRAIN occupies cycles n..n+2.
  - PUSH_HI n+3, PUSH_LO n+4, PUSH_CCR n+5.
  - VECTOR n+6; the first vector instruction is fetched at n+7.
- Total latency is DRAIN_CYCLES+4 cycles, plus the number of extra cycles `pipe_busy` is held at the end of DRAIN.
- `freeze` is high for exactly those cycles. `stack_wr` is high for exactly 3 consecutive cycles. `int_ack`, `flush` and `pc_load` are single-cycle pulses.
- DRAIN_CYCLES=1 is legal: DRAIN lasts one cycle. DRAIN_CYCLES=0 is not supported.

## Structure
- Package `int_seq_pkg`:
  - state enum `int_state_t` (6 states, 3-bit encoding)
  - widths `PC_W`, `DATA_W`, `CCR_W`
  - constant `INT_PUSH_BEATS = 3`
- Sub-module `int_edge_latch`: holds `int_q`, the edge detect and the `pending` flop, with inputs `set_clr` (DRAIN entry) and `rst`.
- Top: FSM, drain counter, save registers, output decode. Target 150–250 lines of RTL.

## Test plan
- Reset then single edge, `pc_in=32'h0001_2345`, `ccr_in=3'b101`, `pipe_busy=0` → `stack_data` sequence 16'h0001, 16'h2345, 16'h0005 on cycles n+3..n+5; `pc_load=1`/`int_ack=1` at n+6; `freeze` high for 7 cycles.
- `pipe_busy` held high for 4 cycles beyond the drain count → PUSH_HI is delayed by 4 cycles; push data is unchanged (captured at DRAIN entry).
- Second edge during PUSH_LO, then `rti_done` 10 cycles after VECTOR → no new sequence while masked; DRAIN is entered on the edge of `clk` after `rti_done`; exactly one extra service.
- Three edges while masked → exactly one sequence after `rti_done`.
- `rst` asserted during PUSH_HI → all outputs 0 asynchronously. After release, with `interrupt` held high, a new sequence starts in the first cycle (reset edge rule).
- Same-cycle `rti_done` and edge → `masked` falls, DRAIN is entered the next cycle, and `stack_data` carries the new `pc_in`.
